vend_controller: RTL and testbench

Central sequencing FSM for the vending machine. It accumulates coin credit, decides vend/cancel, and times the dispense and change-return phases. It also enforces an inactivity timeout. All timing is done in whole seconds by counting the 1 Hz enable pulse from the clock divider. Coin and button inputs arrive already debounced and edge-detected as single-cycle pulses. Outputs drive the dispenser/return actuators and the credit display path.

---
 rtl/vend_controller.sv | 141 ++++++++++++++
 tb/tb_vend_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
// Vending machine sequencing FSM: accumulates coin credit, arbitrates vend/cancel,
// and times dispense, change-return and inactivity phases in whole 1 Hz ticks.
module vend_controller #(
  parameter int PRICE         = 75,
  parameter int CREDIT_W      = 8,
  parameter int CREDIT_MAX    = 250,
  parameter int DISPENSE_SECS = 3,
  parameter int CHANGE_SECS   = 2,
  parameter int TIMEOUT_SECS  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_1hz,
  input  logic                coin_nickel,
  input  logic                coin_dime,
  input  logic                coin_quarter,
  input  logic                btn_vend,
  input  logic                btn_cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                dispensing,
  output logic                returning,
  output logic                coin_reject,
  output logic                insufficient,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  // One extra bit so credit + coin value cannot wrap before the limit compare.
  localparam int SUM_W = CREDIT_W + 1;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_d, change_d;
  logic [7:0]          secs_q, secs_d;
  logic                coin_reject_d, insufficient_d;

  logic [SUM_W-1:0]    coin_sum, credit_ext, credit_plus;
  logic [8:0]          secs_inc;
  logic                coin_in, coin_fits, coin_accept;
  logic                disp_done, chg_done, timeout_hit;

  always_comb begin
    coin_sum    = (coin_nickel  ? SUM_W'(5)  : SUM_W'(0))
                + (coin_dime    ? SUM_W'(10) : SUM_W'(0))
                + (coin_quarter ? SUM_W'(25) : SUM_W'(0));
    credit_ext  = {1'b0, credit};
    credit_plus = credit_ext + coin_sum;
    coin_in     = coin_nickel | coin_dime | coin_quarter;
    coin_fits   = (credit_plus <= SUM_W'(CREDIT_MAX));
    // Phase ends are judged on the count including the tick in this cycle.
    secs_inc    = {1'b0, secs_q} + 9'd1;
    disp_done   = tick_1hz && (secs_inc == 9'(DISPENSE_SECS));
    chg_done    = tick_1hz && (secs_inc == 9'(CHANGE_SECS));
    timeout_hit = tick_1hz && (secs_inc == 9'(TIMEOUT_SECS));
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit;
    change_d       = change_amt;
    coin_accept    = 1'b0;
    insufficient_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (coin_in && coin_fits) begin
          coin_accept = 1'b1;
          state_d     = COLLECT;
        end
      end
      COLLECT: begin
        if (btn_cancel) begin
          change_d = credit;
          credit_d = '0;
          state_d  = CHANGE;
        end else if (btn_vend && (credit_ext >= SUM_W'(PRICE))) begin
          change_d = credit - CREDIT_W'(PRICE);
          credit_d = '0;
          state_d  = DISPENSE;
        end else begin
          insufficient_d = btn_vend;
          // An accepted coin restarts the inactivity window, so it beats the timeout.
          if (coin_in && coin_fits) begin
            coin_accept = 1'b1;
          end else if (timeout_hit) begin
            change_d = credit;
            credit_d = '0;
            state_d  = CHANGE;
          end
        end
      end
      DISPENSE: begin
        if (disp_done) state_d = (change_amt != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (chg_done) begin
          state_d  = IDLE;
          change_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (coin_accept) credit_d = credit_plus[CREDIT_W-1:0];
    coin_reject_d = coin_in && !coin_accept;

    if ((state_d != state_q) || coin_accept) secs_d = '0;
    else if (tick_1hz)                       secs_d = secs_inc[7:0];
    else                                     secs_d = secs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      credit       <= '0;
      change_amt   <= '0;
      secs_q       <= '0;
      dispensing   <= 1'b0;
      returning    <= 1'b0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit       <= credit_d;
      change_amt   <= change_d;
      secs_q       <= secs_d;
      dispensing   <= (state_d == DISPENSE);
      returning    <= (state_d == CHANGE);
      coin_reject  <= coin_reject_d;
      insufficient <= insufficient_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios plus a randomized run against a
// behavioural model that tracks credit, pending change and elapsed ticks.
`timescale 1ns/1ps
module tb_vend_controller;
  localparam int PRICE = 75, CREDIT_MAX = 250;
  localparam int DISPENSE_SECS = 3, CHANGE_SECS = 2, TIMEOUT_SECS = 10;

  logic       clk = 1'b0, rst_n = 1'b0, tick_1hz = 1'b0;
  logic       coin_nickel = 1'b0, coin_dime = 1'b0, coin_quarter = 1'b0;
  logic       btn_vend = 1'b0, btn_cancel = 1'b0;
  logic [7:0] credit, change_amt;
  logic       dispensing, returning, coin_reject, insufficient;
  logic [1:0] state;
  logic [21:0] obs;

  int vectors = 0, miscompares = 0;

  // Model: phase 0 idle, 1 collecting, 2 dispensing, 3 returning change.
  int m_phase, m_credit, m_change, m_ticks;
  bit m_rej, m_ins;

  always #5 clk = ~clk;

  vend_controller #(
    .PRICE(PRICE), .CREDIT_W(8), .CREDIT_MAX(CREDIT_MAX),
    .DISPENSE_SECS(DISPENSE_SECS), .CHANGE_SECS(CHANGE_SECS), .TIMEOUT_SECS(TIMEOUT_SECS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .coin_nickel(coin_nickel), .coin_dime(coin_dime), .coin_quarter(coin_quarter),
    .btn_vend(btn_vend), .btn_cancel(btn_cancel),
    .credit(credit), .change_amt(change_amt), .dispensing(dispensing),
    .returning(returning), .coin_reject(coin_reject), .insufficient(insufficient),
    .state(state)
  );

  assign obs = {state, credit, change_amt, dispensing, returning, coin_reject, insufficient};

  function automatic logic [21:0] exp_vec();
    return {2'(m_phase), 8'(m_credit), 8'(m_change),
            m_phase == 2, m_phase == 3, m_rej, m_ins};
  endfunction

  task automatic model_clear();
    m_phase = 0; m_credit = 0; m_change = 0; m_ticks = 0; m_rej = 0; m_ins = 0;
  endtask

  task automatic model_step(input bit n, d, q, v, c, t);
    int  sum, next, elapsed;
    bit  took;
    sum     = 5 * n + 10 * d + 25 * q;
    took    = 0;
    m_ins   = 0;
    next    = m_phase;
    elapsed = m_ticks + (t ? 1 : 0);
    case (m_phase)
      0: took = (sum > 0) && (m_credit + sum <= CREDIT_MAX);
      1: begin
        if (c) begin
          m_change = m_credit; m_credit = 0; next = 3;
        end else if (v && m_credit >= PRICE) begin
          m_change = m_credit - PRICE; m_credit = 0; next = 2;
        end else begin
          m_ins = v;
          took  = (sum > 0) && (m_credit + sum <= CREDIT_MAX);
          if (!took && t && elapsed == TIMEOUT_SECS) begin
            m_change = m_credit; m_credit = 0; next = 3;
          end
        end
      end
      2: if (t && elapsed == DISPENSE_SECS) next = (m_change != 0) ? 3 : 0;
      3: if (t && elapsed == CHANGE_SECS) begin next = 0; m_change = 0; end
      default: next = 0;
    endcase
    if (took) begin
      m_credit += sum;
      if (m_phase == 0) next = 1;
    end
    m_rej   = (sum > 0) && !took;
    m_ticks = (next != m_phase || took) ? 0 : elapsed;
    m_phase = next;
  endtask

  task automatic drive(input bit n, d, q, v, c, t);
    coin_nickel = n; coin_dime = d; coin_quarter = q;
    btn_vend = v; btn_cancel = c; tick_1hz = t;
    model_step(n, d, q, v, c, t);
    @(posedge clk);
    #1;
    coin_nickel = 0; coin_dime = 0; coin_quarter = 0;
    btn_vend = 0; btn_cancel = 0; tick_1hz = 0;
  endtask

  task automatic coin(input int cents);
    drive(cents == 5, cents == 10, cents == 25, 0, 0, 0);
  endtask

  task automatic ticks(input int k);
    repeat (k) drive(0, 0, 0, 0, 0, 1);
  endtask

  task automatic idle(input int k);
    repeat (k) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== 22'd0) begin
      miscompares++; $display("FAIL reset_outputs: got %h want 000000", obs);
    end
    #1 rst_n = 1'b1;
    idle(1);
    vectors++;
    if (obs !== 22'd0) begin
      miscompares++; $display("FAIL reset_idle: got %h want 000000", obs);
    end
  endtask

  task automatic test_vend_exact();
    logic [1:0] es;
    for (int i = 1; i <= 3; i++) begin
      coin(25);
      vectors++;
      if ({state, credit} !== {2'd1, 8'(25 * i)}) begin
        miscompares++; $display("FAIL quarter_%0d: got st=%0d cr=%0d want st=1 cr=%0d", i, state, credit, 25 * i);
      end
    end
    drive(0, 0, 0, 1, 0, 0);
    vectors++;
    if ({state, credit, change_amt, dispensing} !== {2'd2, 8'd0, 8'd0, 1'b1}) begin
      miscompares++; $display("FAIL vend_exact: got st=%0d cr=%0d ch=%0d disp=%b want 2/0/0/1", state, credit, change_amt, dispensing);
    end
    for (int i = 1; i <= 3; i++) begin
      idle(2);
      ticks(1);
      es = (i < 3) ? 2'd2 : 2'd0;
      vectors++;
      if ({state, dispensing} !== {es, i < 3}) begin
        miscompares++; $display("FAIL dispense_tick_%0d: got st=%0d disp=%b want st=%0d", i, state, dispensing, es);
      end
    end
  endtask

  task automatic test_vend_change();
    coin(25); coin(25); coin(25); coin(10); coin(5);
    vectors++;
    if (credit !== 8'd90) begin
      miscompares++; $display("FAIL credit_90: got %0d want 90", credit);
    end
    drive(0, 0, 0, 1, 0, 0);
    vectors++;
    if ({state, change_amt} !== {2'd2, 8'd15}) begin
      miscompares++; $display("FAIL vend_change: got st=%0d ch=%0d want st=2 ch=15", state, change_amt);
    end
    ticks(3);
    vectors++;
    if ({state, returning, dispensing, change_amt} !== {2'd3, 1'b1, 1'b0, 8'd15}) begin
      miscompares++; $display("FAIL enter_change: got st=%0d ret=%b disp=%b ch=%0d want 3/1/0/15", state, returning, dispensing, change_amt);
    end
    ticks(1);
    vectors++;
    if ({state, returning} !== {2'd3, 1'b1}) begin
      miscompares++; $display("FAIL change_tick1: got st=%0d ret=%b want 3/1", state, returning);
    end
    ticks(1);
    vectors++;
    if ({state, returning, change_amt} !== {2'd0, 1'b0, 8'd0}) begin
      miscompares++; $display("FAIL change_done: got st=%0d ret=%b ch=%0d want 0/0/0", state, returning, change_amt);
    end
  endtask

  task automatic test_insufficient();
    coin(25); coin(25);
    drive(0, 0, 0, 1, 0, 0);
    vectors++;
    if ({insufficient, state, credit} !== {1'b1, 2'd1, 8'd50}) begin
      miscompares++; $display("FAIL insufficient: got ins=%b st=%0d cr=%0d want 1/1/50", insufficient, state, credit);
    end
    idle(1);
    vectors++;
    if (insufficient !== 1'b0) begin
      miscompares++; $display("FAIL insufficient_pulse: got %b want 0", insufficient);
    end
    drive(0, 0, 0, 0, 1, 0);
    vectors++;
    if ({state, change_amt, credit, returning} !== {2'd3, 8'd50, 8'd0, 1'b1}) begin
      miscompares++; $display("FAIL cancel_50: got st=%0d ch=%0d cr=%0d ret=%b want 3/50/0/1", state, change_amt, credit, returning);
    end
    ticks(2);
  endtask

  task automatic test_credit_limit();
    repeat (9) coin(25);
    coin(10); coin(5);
    vectors++;
    if (credit !== 8'd240) begin
      miscompares++; $display("FAIL credit_240: got %0d want 240", credit);
    end
    coin(10);
    vectors++;
    if ({credit, coin_reject} !== {8'd250, 1'b0}) begin
      miscompares++; $display("FAIL credit_250: got cr=%0d rej=%b want 250/0", credit, coin_reject);
    end
    coin(5);
    vectors++;
    if ({credit, coin_reject} !== {8'd250, 1'b1}) begin
      miscompares++; $display("FAIL over_limit: got cr=%0d rej=%b want 250/1", credit, coin_reject);
    end
    idle(1);
    vectors++;
    if (coin_reject !== 1'b0) begin
      miscompares++; $display("FAIL reject_pulse: got %b want 0", coin_reject);
    end
    drive(0, 0, 0, 0, 1, 0);
    ticks(2);
    drive(1, 1, 1, 0, 0, 0);
    vectors++;
    if ({state, credit, coin_reject} !== {2'd1, 8'd40, 1'b0}) begin
      miscompares++; $display("FAIL three_coins: got st=%0d cr=%0d rej=%b want 1/40/0", state, credit, coin_reject);
    end
    drive(0, 0, 0, 0, 1, 0);
    ticks(2);
  endtask

  task automatic test_timeout();
    coin(25); coin(5);
    ticks(9);
    vectors++;
    if ({state, credit} !== {2'd1, 8'd30}) begin
      miscompares++; $display("FAIL tick9_wait: got st=%0d cr=%0d want 1/30", state, credit);
    end
    ticks(1);
    vectors++;
    if ({state, change_amt, credit} !== {2'd3, 8'd30, 8'd0}) begin
      miscompares++; $display("FAIL timeout: got st=%0d ch=%0d cr=%0d want 3/30/0", state, change_amt, credit);
    end
    ticks(2);
    coin(25); coin(5);
    ticks(8);
    drive(1, 0, 0, 0, 0, 1);
    ticks(9);
    vectors++;
    if ({state, credit} !== {2'd1, 8'd35}) begin
      miscompares++; $display("FAIL timeout_restart: got st=%0d cr=%0d want 1/35", state, credit);
    end
    ticks(1);
    vectors++;
    if ({state, change_amt} !== {2'd3, 8'd35}) begin
      miscompares++; $display("FAIL timeout_late: got st=%0d ch=%0d want 3/35", state, change_amt);
    end
    ticks(2);
  endtask

  task automatic test_dispense_coin();
    coin(25); coin(25); coin(25);
    drive(0, 0, 0, 1, 0, 0);
    coin(5);
    vectors++;
    if ({state, credit, coin_reject} !== {2'd2, 8'd0, 1'b1}) begin
      miscompares++; $display("FAIL dispense_coin: got st=%0d cr=%0d rej=%b want 2/0/1", state, credit, coin_reject);
    end
    ticks(3);
  endtask

  task automatic test_back_to_back();
    coin(25); coin(25); coin(25);
    drive(0, 0, 0, 1, 0, 1);
    ticks(2);
    vectors++;
    if (state !== 2'd2) begin
      miscompares++; $display("FAIL entry_tick: got st=%0d want 2", state);
    end
    ticks(1);
    coin(25);
    vectors++;
    if ({state, credit} !== {2'd1, 8'd25}) begin
      miscompares++; $display("FAIL first_idle_coin: got st=%0d cr=%0d want 1/25", state, credit);
    end
    drive(0, 0, 0, 0, 1, 0);
    ticks(2);
  endtask

  task automatic test_cancel_reset();
    coin(25); coin(25); coin(25); coin(5);
    drive(0, 0, 0, 1, 1, 0);
    vectors++;
    if ({state, change_amt, returning} !== {2'd3, 8'd80, 1'b1}) begin
      miscompares++; $display("FAIL vend_cancel: got st=%0d ch=%0d ret=%b want 3/80/1", state, change_amt, returning);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 22'd0) begin
      miscompares++; $display("FAIL async_reset: got %h want 000000", obs);
    end
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    bit n, d, q, v, c, t;
    int fails;
    do_reset();
    fails = 0;
    for (int i = 0; i < 4000 && fails < 20; i++) begin
      n = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 5) == 0);
      q = ($urandom_range(0, 4) == 0);
      v = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 39) == 0);
      t = ($urandom_range(0, 5) == 0);
      drive(n, d, q, v, c, t);
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++; fails++;
        $display("FAIL random_cycle_%0d: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_vend_exact();
    test_vend_change();
    test_insufficient();
    test_credit_limit();
    test_timeout();
    test_dispense_coin();
    test_back_to_back();
    test_cancel_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
